hazard3_apb_initiator: RTL

//  Single-outstanding APB3 requester (initiator) driving peripheral responders such as
//  the RISC-V timer, UART and GPIO blocks from a simple valid/ready request/response port.

---
 rtl/hazard3_apb_initiator.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/hazard3_apb_initiator.sv
// hazard3_apb_initiator: single-outstanding APB3 requester with a valid/ready request and
// response port and a wait-state timeout that turns a hung responder into an error response.
module hazard3_apb_initiator #(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned TIMEOUT = 256,
    parameter int unsigned CNT_W   = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_write,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] paddr,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [31:0]       pwdata,
    input  logic [31:0]       prdata,
    input  logic              pready,
    input  logic              pslverr
);

    typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

    // Abort fires on the ACCESS cycle where count has reached TIMEOUT-1 (the TIMEOUT-th cycle).
    localparam bit               TimeoutEn = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] CntLast   = CNT_W'(TIMEOUT - 1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [ADDR_W-1:0]   paddr_q, paddr_d;
    logic                psel_q, psel_d;
    logic                penable_q, penable_d;
    logic                pwrite_q, pwrite_d;
    logic [31:0]         pwdata_q, pwdata_d;
    logic                resp_valid_q, resp_valid_d;
    logic [31:0]         resp_rdata_q, resp_rdata_d;
    logic                resp_err_q, resp_err_d;
    logic                timeout_hit;

    assign timeout_hit = TimeoutEn && (count_q == CntLast);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: one transfer walks IDLE -> SETUP -> ACCESS -> RESP -> IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (req_valid) state_d = StSetup;
            StSetup:  state_d = StAccess;
            StAccess: if (pready || timeout_hit) state_d = StResp;
            StResp:   if (resp_ready) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Output logic: next values for the registered APB and response outputs.
    always_comb begin
        count_d      = count_q;
        paddr_d      = paddr_q;
        psel_d       = psel_q;
        penable_d    = penable_q;
        pwrite_d     = pwrite_q;
        pwdata_d     = pwdata_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    paddr_d   = req_addr;
                    pwrite_d  = req_write;
                    pwdata_d  = req_wdata;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                end
            end
            StSetup: begin
                penable_d = 1'b1;
                count_d   = '0;
            end
            StAccess: begin
                if (pready) begin
                    // pready wins over a timeout landing in the same cycle.
                    resp_err_d   = pslverr;
                    resp_rdata_d = pwrite_q ? 32'h0 : prdata;
                    psel_d       = 1'b0;
                    penable_d    = 1'b0;
                    resp_valid_d = 1'b1;
                end else begin
                    count_d = count_q + 1'b1;
                    if (timeout_hit) begin
                        resp_err_d   = 1'b1;
                        resp_rdata_d = 32'h0;
                        psel_d       = 1'b0;
                        penable_d    = 1'b0;
                        resp_valid_d = 1'b1;
                    end
                end
            end
            StResp: begin
                if (resp_ready) resp_valid_d = 1'b0;
            end
            default: ;
        endcase
    end

    // Datapath registers behind every output except req_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q      <= '0;
            paddr_q      <= '0;
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            pwrite_q     <= 1'b0;
            pwdata_q     <= 32'h0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
        end else begin
            count_q      <= count_d;
            paddr_q      <= paddr_d;
            psel_q       <= psel_d;
            penable_q    <= penable_d;
            pwrite_q     <= pwrite_d;
            pwdata_q     <= pwdata_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign req_ready  = (state_q == StIdle);
    assign paddr      = paddr_q;
    assign psel       = psel_q;
    assign penable    = penable_q;
    assign pwrite     = pwrite_q;
    assign pwdata     = pwdata_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule
